// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format codes for the RV32I immediate generator.
package imm_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I immediate decoder: instruction word to extended immediate,
// format code and illegal-opcode flag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]                   instruction,
  output logic signed [DATA_WIDTH-1:0]  sextimm,
  output imm_fmt_t                      imm_fmt,
  output logic                          illegal
);

  function automatic logic signed [DATA_WIDTH-1:0] sext32(input logic signed [31:0] v);
    return DATA_WIDTH'(v);
  endfunction

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] raw;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  // Every immediate is first assembled at 32 bits; shamt has bit 31 clear so it zero-extends.
  always_comb begin
    raw     = '0;
    imm_fmt = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_fmt = FMT_SH;
          raw     = {27'b0, instruction[24:20]};
        end else begin
          imm_fmt = FMT_I;
          raw     = {{20{instruction[31]}}, instruction[31:20]};
        end
      end
      LOAD, JALR, SYSTEM: begin
        imm_fmt = FMT_I;
        raw     = {{20{instruction[31]}}, instruction[31:20]};
      end
      STORE: begin
        imm_fmt = FMT_S;
        raw     = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      BRANCH: begin
        imm_fmt = FMT_B;
        raw     = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        imm_fmt = FMT_U;
        raw     = {instruction[31:12], 12'b0};
      end
      JAL: begin
        imm_fmt = FMT_J;
        raw     = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      OP, FENCE: begin
        imm_fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign sextimm = sext32(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main register M,
// skid register K) so the producer sees a registered ready and throughput is kept.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sextimm,
  output logic [2:0]            imm_fmt,
  output logic                  illegal
);

  logic signed [DATA_WIDTH-1:0] dec_imm_p0;
  imm_fmt_t                     dec_fmt_p0;
  logic                         dec_ill_p0;

  logic                         m_vld_p1;
  logic signed [DATA_WIDTH-1:0] m_imm_p1;
  imm_fmt_t                     m_fmt_p1;
  logic                         m_ill_p1;

  logic                         k_vld_p1;
  logic signed [DATA_WIDTH-1:0] k_imm_p1;
  imm_fmt_t                     k_fmt_p1;
  logic                         k_ill_p1;

  logic in_fire;
  logic out_fire;

  imm_decode_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .instruction (instruction),
    .sextimm     (dec_imm_p0),
    .imm_fmt     (dec_fmt_p0),
    .illegal     (dec_ill_p0)
  );

  assign in_ready = ~k_vld_p1;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_vld_p1 & out_ready;

  // Stage p0 -> p1: decoded word lands in M, or in K when M is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_vld_p1 <= 1'b0;
      m_imm_p1 <= '0;
      m_fmt_p1 <= FMT_NONE;
      m_ill_p1 <= 1'b0;
      k_vld_p1 <= 1'b0;
      k_imm_p1 <= '0;
      k_fmt_p1 <= FMT_NONE;
      k_ill_p1 <= 1'b0;
    end else if (k_vld_p1) begin
      // in_ready is low here, so only the K -> M move can happen.
      if (out_fire) begin
        m_imm_p1 <= k_imm_p1;
        m_fmt_p1 <= k_fmt_p1;
        m_ill_p1 <= k_ill_p1;
        k_vld_p1 <= 1'b0;
      end
    end else if (in_fire) begin
      if (!m_vld_p1 || out_fire) begin
        m_vld_p1 <= 1'b1;
        m_imm_p1 <= dec_imm_p0;
        m_fmt_p1 <= dec_fmt_p0;
        m_ill_p1 <= dec_ill_p0;
      end else begin
        k_vld_p1 <= 1'b1;
        k_imm_p1 <= dec_imm_p0;
        k_fmt_p1 <= dec_fmt_p0;
        k_ill_p1 <= dec_ill_p0;
      end
    end else if (out_fire) begin
      m_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = m_vld_p1;
  assign sextimm   = m_imm_p1;
  assign imm_fmt   = m_fmt_p1;
  assign illegal   = m_ill_p1;

endmodule
